// File: rtl/div_pkg.sv
// div_pkg
//   Shared definitions for the sequential restoring divider.
//   W_DEF        default divisor/remainder width (dividend/quotient are 2*W)
//   state_e      controller state encoding
//   DBZ_QUOTIENT all-ones quotient reported on divide-by-zero (slice to 2*W)
package div_pkg;

  localparam int W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Wide enough for any practical W; users take the low 2*W bits.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/cond_sub.sv
// cond_sub
//   N-bit ripple-borrow subtractor built from full-adder cells (a + ~b + 1).
//   Ports:
//     a_i         minuend
//     b_i         subtrahend
//     diff_o      a_i - b_i (modulo 2^N)
//     no_borrow_o 1 when a_i >= b_i
module cond_sub
  import div_pkg::*;
#(
  parameter int N = W_DEF + 1
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         no_borrow_o
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic bn;
    assign bn          = ~b_i[i];
    assign diff_o[i]   = a_i[i] ^ bn ^ carry[i];
    assign carry[i+1]  = (a_i[i] & bn) | (a_i[i] & carry[i]) | (bn & carry[i]);
  end

  // Carry out of a + ~b + 1 is the inverted borrow.
  assign no_borrow_o = carry[N];

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle restoring divider, one quotient bit per clock, MSB first.
//   Ports:
//     clk, rst      clock and synchronous active-high reset
//     start         request, accepted in IDLE or in the DONE pulse cycle
//     dividend      2W-bit dividend, sampled on the accepting edge
//     divisor       W-bit divisor, sampled on the accepting edge
//     busy          high while quotient bits are being produced
//     done          one-cycle pulse, results valid
//     quotient      2W-bit quotient, held until next result
//     remainder     W-bit remainder, held until next result
//     div_by_zero   set with done when the divisor was zero
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | one restoring step per edge, 2W steps
//   DONE  | done pulse; start accepted here. Entered with done low on a
//         | zero divisor, so that result appears one edge later.
module seq_divider
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div_by_zero
);

  localparam int                CNT_W    = $clog2(2 * W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(2 * W - 1);

  state_e           state_q;
  logic             busy_q, done_q, dbz_q;
  logic [2*W-1:0]   quot_q, dvd_q, qsr_q, qsr_d;
  logic [W-1:0]     rem_q, dvs_q;
  logic [W:0]       pr_q, pr_shift, pr_d, diff;
  logic             no_borrow;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             unused_pr_msb;

  assign pr_shift = {pr_q[W-1:0], dvd_q[2*W-1]};

  cond_sub #(.N(W + 1)) u_sub (
    .a_i         (pr_shift),
    .b_i         ({1'b0, dvs_q}),
    .diff_o      (diff),
    .no_borrow_o (no_borrow)
  );

  assign pr_d  = no_borrow ? diff : pr_shift;
  assign qsr_d = {qsr_q[2*W-2:0], no_borrow};

  // Restoring keeps the stored partial remainder below the divisor,
  // so its top bit is always zero between steps.
  assign unused_pr_msb = pr_q[W];

  assign accept = start && ((state_q == IDLE) || ((state_q == DONE) && done_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qsr_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        pr_q  <= '0;
        qsr_q <= '0;
        cnt_q <= CNT_LAST;
        dbz_q <= 1'b0;
        if (divisor != '0) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end else begin
          state_q <= DONE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          RUN: begin
            pr_q  <= pr_d;
            qsr_q <= qsr_d;
            dvd_q <= {dvd_q[2*W-2:0], 1'b0};
            if (cnt_q == '0) begin
              quot_q  <= qsr_d;
              rem_q   <= pr_d[W-1:0];
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DONE: begin
            if (!done_q) begin
              quot_q <= DBZ_QUOTIENT[2*W-1:0];
              rem_q  <= dvd_q[W-1:0];
              dbz_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
